// File: rtl/dcs_pkg.sv
// Shared constants, FSM states and the round/shift/saturate step for the
// DCSformer result requantizer.
package dcs_pkg;
  localparam int VEC_LEN = 8;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int IDX_W   = $clog2(VEC_LEN);
  localparam int SH_W    = 5;

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  // Round half-up by s bits, then clamp to the output range. The sum carries
  // one extra bit so an all-ones word cannot wrap to zero.
  function automatic logic [OUT_W-1:0] rq_sat(input logic [IN_W-1:0] w,
                                              input logic [SH_W-1:0] s);
    logic [IN_W:0] rnd;
    logic [IN_W:0] sum;
    logic [IN_W:0] shd;
    rnd = '0;
    if (s != '0) rnd = {{IN_W{1'b0}}, 1'b1} << (s - SH_W'(1));
    sum = {1'b0, w} + rnd;
    shd = sum >> s;
    return (|shd[IN_W:OUT_W]) ? {OUT_W{1'b1}} : shd[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/dcs_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module dcs_lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  i_val,
  output logic [CW-1:0] o_cnt
);
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (i_val[i]) o_cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/dcs_vec_requant.sv
// Ping-pong capture of 8-word vectors with running max/argmax, then
// shared-shift requantization to bytes over a valid/ready stream.
module dcs_vec_requant
  import dcs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  argmax_idx,
  output logic [SH_W-1:0]   shift_amt,
  output logic              busy,
  output logic              overflow
);
  logic [1:0][VEC_LEN-1:0][IN_W-1:0] r_bank;
  logic [1:0][IN_W-1:0]              r_max;
  logic [1:0][IDX_W-1:0]             r_amax;
  logic [1:0]                        r_full;
  logic [IDX_W-1:0]                  r_wcnt;
  logic                              r_wr_bank;
  logic                              r_drop;
  logic [IN_W-1:0]                   r_run_max;
  logic [IDX_W-1:0]                  r_run_idx;
  logic                              r_ovf;

  state_t                            r_state, w_state_nx;
  logic                              r_rd_bank;
  logic [IDX_W-1:0]                  r_ridx;
  logic [SH_W-1:0]                   r_shift;
  logic [IDX_W-1:0]                  r_oamax;

  logic                              w_xfer, w_last, w_first, w_drop, w_take;
  logic                              w_done;
  logic [1:0]                        w_rel, w_set;
  logic [IN_W-1:0]                   w_new_max;
  logic [IDX_W-1:0]                  w_new_idx;
  logic [5:0]                        w_lzc;
  logic [SH_W-1:0]                   w_shift;

  assign w_xfer  = (r_state == SEND) & out_ready;
  assign w_last  = (r_ridx == IDX_W'(VEC_LEN - 1));
  assign w_rel   = (w_xfer & w_last) ? (2'b01 << r_rd_bank) : 2'b00;

  // A bank released on this edge counts as free for an arriving word 0.
  assign w_first = in_valid & (r_wcnt == '0);
  assign w_drop  = w_first ? (r_full[r_wr_bank] & ~w_rel[r_wr_bank]) : r_drop;
  assign w_take  = w_first | (in_data > r_run_max);
  assign w_new_max = w_take ? in_data : r_run_max;
  assign w_new_idx = w_take ? r_wcnt  : r_run_idx;
  assign w_done  = in_valid & (r_wcnt == IDX_W'(VEC_LEN - 1));
  assign w_set   = (w_done & ~w_drop) ? (2'b01 << r_wr_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_wr_bank <= 1'b0;
      r_drop    <= 1'b0;
      r_run_max <= '0;
      r_run_idx <= '0;
      r_full    <= '0;
      r_max     <= '0;
      r_amax    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_rel) | w_set;
      if (in_valid) begin
        r_wcnt    <= r_wcnt + IDX_W'(1);
        r_drop    <= w_drop;
        r_run_max <= w_new_max;
        r_run_idx <= w_new_idx;
        if (w_first & w_drop) r_ovf <= 1'b1;
        if (w_done & ~w_drop) begin
          r_max[r_wr_bank]  <= w_new_max;
          r_amax[r_wr_bank] <= w_new_idx;
          r_wr_bank         <= ~r_wr_bank;
        end
      end
    end
  end

  // Vector payload needs no reset: nothing reads a bank until it is full.
  always_ff @(posedge clk) begin
    if (in_valid & ~w_drop) r_bank[r_wr_bank][r_wcnt] <= in_data;
  end

  dcs_lzc #(.W(IN_W), .CW(6)) u_lzc (
    .i_val (r_max[r_rd_bank]),
    .o_cnt (w_lzc)
  );

  // MSB position p = 31 - lzc, so shift = p - 7 = 24 - lzc when positive.
  assign w_shift = (w_lzc >= 6'd24) ? '0 : SH_W'(6'd24 - w_lzc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
      r_ridx    <= '0;
      r_shift   <= '0;
      r_oamax   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == CALC) begin
        r_shift <= w_shift;
        r_oamax <= r_amax[r_rd_bank];
        r_ridx  <= '0;
      end else if (w_xfer) begin
        r_ridx <= r_ridx + IDX_W'(1);
        if (w_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    out_valid  = 1'b0;
    case (r_state)
      IDLE: if (r_full[r_rd_bank]) w_state_nx = CALC;
      CALC: w_state_nx = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (w_xfer & w_last) w_state_nx = r_full[~r_rd_bank] ? CALC : IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign out_data   = out_valid ? rq_sat(r_bank[r_rd_bank][r_ridx], r_shift) : '0;
  assign out_last   = out_valid & w_last;
  assign argmax_idx = r_oamax;
  assign shift_amt  = r_shift;
  assign busy       = (|r_full) | (r_wcnt != '0);
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_dcs_vec_requant.sv
// Randomized + directed bench for dcs_vec_requant against a queue-based
// vector model.
module tb_dcs_vec_requant;
  logic        clk, rst_n, in_valid, out_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, busy, overflow;
  logic [7:0]  out_data;
  logic [2:0]  argmax_idx;
  logic [4:0]  shift_amt;

  dcs_vec_requant dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .argmax_idx(argmax_idx), .shift_amt(shift_amt),
    .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][7:0] b;
    logic [2:0]      a;
    logic [4:0]      s;
  } vexp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [2:0] a;
    logic [4:0] s;
  } got_t;

  int total = 0;
  int bad   = 0;

  vexp_t            exp_q[$];
  got_t             got_q[$];
  int               oidx = 0;
  int               wcnt = 0;
  bit               m_drop = 0;
  bit               m_ovf  = 0;
  logic [7:0][31:0] cur;

  task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, g, e, $time);
    end
  endtask

  // Expected result from plain arithmetic: lowest-index max, smallest shift
  // that brings the max into byte range, rounded and clamped elements.
  function automatic vexp_t make(input logic [7:0][31:0] v);
    vexp_t r;
    longint unsigned mx, x;
    int s;
    r = '0;
    mx = v[0];
    for (int i = 1; i < 8; i++)
      if (v[i] > mx) begin mx = v[i]; r.a = 3'(i); end
    s = 0;
    while ((mx >> s) > 255) s++;
    r.s = 5'(s);
    for (int i = 0; i < 8; i++) begin
      x = v[i];
      if (s > 0) x = x + (64'd1 << (s - 1));
      x = x >> s;
      if (x > 255) x = 255;
      r.b[i] = 8'(x);
    end
    return r;
  endfunction

  // Model and compare process; the edge following this sample applies the
  // transfer/capture being modelled.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_argmax", argmax_idx, 0);
      chk("rst_shift", shift_amt, 0);
      exp_q.delete();
      oidx = 0; wcnt = 0; m_drop = 0; m_ovf = 0;
    end else begin
      chk("busy", busy, (exp_q.size() != 0 || wcnt != 0));
      chk("overflow", overflow, m_ovf);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          chk("out_data", out_data, exp_q[0].b[oidx]);
          chk("out_last", out_last, (oidx == 7));
          chk("argmax_idx", argmax_idx, exp_q[0].a);
          chk("shift_amt", shift_amt, exp_q[0].s);
          if (out_ready) begin
            got_q.push_back({out_data, out_last, argmax_idx, shift_amt});
            if (oidx == 7) begin exp_q.pop_front(); oidx = 0; end
            else oidx++;
          end
        end
      end
      if (in_valid) begin
        if (wcnt == 0) begin
          m_drop = (exp_q.size() == 2);
          if (m_drop) m_ovf = 1;
        end
        cur[wcnt] = in_data;
        wcnt++;
        if (wcnt == 8) begin
          wcnt = 0;
          if (!m_drop) exp_q.push_back(make(cur));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [7:0][31:0] v, input bit rnd);
    for (int i = 0; i < 8; i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 0; out_ready = 1'($urandom_range(0, 1)); step();
        end
        out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1; in_data = v[i];
      step();
    end
    in_valid = 0; in_data = '0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid || busy) && n < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    chk("drain_timeout", (n >= 2000), 0);
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("wait_out_valid_timeout", (n >= 20), 0);
  endtask

  task automatic chk_got(input string nm, input int base, input vexp_t e);
    for (int i = 0; i < 8; i++) begin
      chk({nm, "_data"}, got_q[base+i].d, e.b[i]);
      chk({nm, "_last"}, got_q[base+i].l, (i == 7));
      chk({nm, "_argmax"}, got_q[base+i].a, e.a);
      chk({nm, "_shift"}, got_q[base+i].s, e.s);
    end
  endtask

  initial begin
    logic [7:0][31:0] v, v1, v2, v3;
    vexp_t m;
    logic [7:0] held_d;
    logic [2:0] held_a;
    logic [4:0] held_s;

    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    // T1: 1..8 contiguous, latency and plain pass-through.
    out_ready = 1;
    for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
    got_q.delete();
    send_vec(v, 0);
    @(negedge clk); chk("lat_n1", out_valid, 0);
    @(negedge clk); chk("lat_n2", out_valid, 0);
    @(negedge clk); chk("lat_n3", out_valid, 1);
    step();
    drain(0);
    chk("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", got_q[i].d, 8'(i + 1));
      chk("t1_last", got_q[i].l, (i == 7));
      chk("t1_argmax", got_q[i].a, 7);
      chk("t1_shift", got_q[i].s, 0);
    end

    // T2: max 0x1000 -> shift 5; 0x30 rounds to 2, max to 128.
    v = '0; v[0] = 32'h30; v[1] = 32'h1000; v[2] = 32'd5; v[5] = 32'hFFF;
    m = make(v);
    chk("pin_t2_shift", m.s, 5);
    chk("pin_t2_b0", m.b[0], 2);
    chk("pin_t2_b1", m.b[1], 128);
    got_q.delete();
    send_vec(v, 0);
    drain(0);
    chk("t2_count", got_q.size(), 8);
    chk("t2_b0", got_q[0].d, 2);
    chk("t2_b1", got_q[1].d, 128);
    chk("t2_b5", got_q[5].d, 128);
    chk("t2_shift", got_q[0].s, 5);
    chk("t2_argmax", got_q[0].a, 1);

    // T3: all ones saturates rather than wrapping; tie keeps index 0.
    for (int i = 0; i < 8; i++) v[i] = 32'hFFFF_FFFF;
    m = make(v);
    chk("pin_t3_shift", m.s, 24);
    chk("pin_t3_b3", m.b[3], 255);
    got_q.delete();
    send_vec(v, 0);
    drain(0);
    chk("t3_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_data", got_q[i].d, 255);
    chk("t3_shift", got_q[0].s, 24);
    chk("t3_argmax", got_q[0].a, 0);

    // T4: stall three cycles after the third transfer.
    for (int i = 0; i < 8; i++) v[i] = 32'(i * 700 + 3);
    out_ready = 0;
    got_q.delete();
    send_vec(v, 0);
    wait_ov();
    out_ready = 1;
    repeat (3) step();
    out_ready = 0;
    held_d = out_data; held_a = argmax_idx; held_s = shift_amt;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, held_d);
      chk("t4_hold_argmax", argmax_idx, held_a);
      chk("t4_hold_shift", shift_amt, held_s);
    end
    drain(0);
    chk("t4_count", got_q.size(), 8);
    chk_got("t4", 0, make(v));

    // T5: three vectors with no drain; the third is dropped.
    for (int i = 0; i < 8; i++) begin
      v1[i] = 32'(i * 37 + 1);
      v2[i] = 32'h0010_0000 >> i;
      v3[i] = 32'd99;
    end
    out_ready = 0;
    got_q.delete();
    send_vec(v1, 0); send_vec(v2, 0); send_vec(v3, 0);
    step();
    chk("t5_overflow", overflow, 1);
    drain(0);
    chk("t5_count", got_q.size(), 16);
    chk_got("t5_v1", 0, make(v1));
    chk_got("t5_v2", 8, make(v2));
    chk("t5_overflow_sticky", overflow, 1);

    // T6: zero vector, then reset mid-SEND.
    v = '0;
    got_q.delete();
    send_vec(v, 0);
    drain(0);
    chk("t6_count", got_q.size(), 8);
    chk("t6_data", got_q[4].d, 0);
    chk("t6_shift", got_q[0].s, 0);
    chk("t6_argmax", got_q[0].a, 0);
    out_ready = 0;
    for (int i = 0; i < 8; i++) v[i] = 32'(i * 3 + 1000);
    send_vec(v, 0);
    wait_ov();
    rst_n = 0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_overflow", overflow, 0);
    step();
    rst_n = 1;
    step();
    out_ready = 1;
    got_q.delete();
    v[3] = 32'h0000_4000;
    send_vec(v, 0);
    drain(0);
    chk("t6_after_count", got_q.size(), 8);
    chk_got("t6_after", 0, make(v));

    // Random vectors, gaps and backpressure.
    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom() >> $urandom_range(0, 31);
      if (n == 5) v[2] = v[6];
      send_vec(v, 1);
    end
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcs_vec_requant.md
Name: dcs_vec_requant

Overview:
Downstream consumer of the DCSformer result stream. It captures each 8-word, 32-bit vector delivered on the o_valid/o_data burst and finds the vector's maximum and argmax. It then requantizes every element to 8 bits with one shared, data-dependent right shift (round-half-up, saturating) and emits the bytes to the next layer over a valid/ready handshake. Two capture banks (ping-pong) absorb a new vector while the previous one drains, because the upstream stream has no backpressure.

Parameters:
VEC_LEN, 8, words per vector; must be a power of 2
IN_W, 32, input word width
OUT_W, 8, output element width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid; no ready, so a word is taken on every cycle in_valid=1
in_data  input  IN_W  upstream word, unsigned
out_valid  output  1  requantized element valid
out_data  output  OUT_W  requantized element
out_last  output  1  high with element VEC_LEN-1
out_ready  input  1  downstream accepts; transfer = out_valid & out_ready
argmax_idx  output  log2(VEC_LEN)  index of the vector max; valid and held while out_valid
shift_amt  output  5  shift applied to the current vector; valid and held while out_valid
busy  output  1  high while any bank is full or a vector is partially captured
overflow  output  1  sticky flag: a vector was dropped

Behaviour:
- Reset (async): all outputs 0; word count 0; write bank 0; both banks empty; FSM IDLE; overflow cleared.
- Capture:
  - On each posedge with in_valid=1, word at count k is written to bank wr_bank, slot k, and k increments.
  - in_valid gaps are allowed; the count persists across gaps.
  - A running max/argmax is kept per vector. The update uses strict greater-than, so on a tie the lowest index wins. All-zero vector gives argmax 0.
  - On word VEC_LEN-1: the bank is marked full with its max/argmax, wr_bank toggles, and k wraps to 0.
- Drop rule:
  - If word 0 arrives while the target bank is still full, the whole vector is counted but not stored.
  - Max/argmax of the full bank are left untouched and wr_bank does not toggle.
  - overflow is set and stays 1 until reset.
- Output FSM:
  - IDLE: if bank rd_bank is full, go to CALC.
  - CALC (1 cycle): compute p = bit position of the MSB of max, using a leading-zero count. shift_amt = (p>7) ? p-7 : 0. Latch shift_amt and argmax_idx; element index i=0. Go to SEND.
  - SEND: out_valid=1 and out_data = sat255((word_i + (s ? 1<<(s-1) : 0)) >> s).
    - The sum is computed at IN_W+1 bits, so no carry is lost.
    - out_data, out_last and the latched fields are held stable while out_valid & !out_ready.
    - On each transfer i increments.
    - On the transfer with i=VEC_LEN-1: the bank is released, rd_bank toggles, and the FSM goes to CALC if the other bank is full, otherwise IDLE.
- Latency: last input word at posedge T -> CALC in cycle T+1 -> out_valid=1 from cycle T+2 (when the FSM is IDLE).
- Simultaneous events:
  - A bank release and a capture completion on the same edge are both honoured.
  - A bank released on edge E may be written from edge E onward, with no drop.
  - Capture into one bank while the other drains is normal operation.
- Reset mid-operation: vector contents are discarded and no partial output is emitted after reset.
- Width rules: max is held at IN_W bits; shift range is 0..24; the saturation threshold is 2^OUT_W-1.

Decomposition:
- Shared package dcs_pkg:
  - VEC_LEN, IN_W and OUT_W constants
  - state enum {IDLE, CALC, SEND}
  - IDX_W = $clog2(VEC_LEN)
  - function for the round/shift/saturate step
- One sub-module: dcs_lzc, a combinational 32-bit leading-zero counter used in CALC.

Test Plan:
- Vector 1,2,...,8 contiguous, out_ready=1 -> shift_amt=0, argmax_idx=7, out_data 1..8, out_last on 8, first out_valid 2 cycles after the last input.
- Vector with max 0x0000_1000 and element 0x30 -> shift_amt=5; element 0x30 gives out_data 2; the max gives 128.
- Vector of eight 0xFFFF_FFFF -> shift_amt=24, all out_data=255 (saturated, not wrapped to 0), argmax_idx=0 (tie rule).
- out_ready low for 3 cycles after the 3rd transfer -> out_data, argmax_idx and shift_amt held for those cycles, no element lost or repeated, 8 transfers total.
- Three back-to-back vectors with out_ready=0 -> vectors 1 and 2 retained, vector 3 dropped, overflow=1 (sticky). After out_ready=1, vectors 1 then 2 are emitted intact.
- All-zero vector, plus rst_n pulsed mid-SEND -> zero vector gives shift 0, argmax 0, out_data 0. The reset gives immediate out_valid=0, busy=0, overflow=0, and the next vector is processed normally.
